// File: rtl/rx_shift_engine_if.sv
// rtl/rx_shift_engine_if.sv - serial line, frame configuration and received-frame bundle
interface rx_shift_engine_if #(
    parameter int BAUD_W = 19
);
    logic              rx;
    logic [BAUD_W-1:0] baud_k;
    logic              eight;
    logic              pen;
    logic [9:0]        shiftData;
    logic              eight_q;
    logic              pen_q;
    logic              busy;
    logic              done;
    logic              ferr;

    modport master (
        output rx, baud_k, eight, pen,
        input  shiftData, eight_q, pen_q, busy, done, ferr
    );

    modport slave (
        input  rx, baud_k, eight, pen,
        output shiftData, eight_q, pen_q, busy, done, ferr
    );
endinterface

// File: rtl/rx_shift_engine.sv
// rtl/rx_shift_engine.sv - UART receive front end: sync, start qualify, bit timing, frame shift-in
module rx_shift_engine #(
    parameter int BAUD_W      = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    rx_shift_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

    localparam logic [BAUD_W-1:0] ONE = {{(BAUD_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [BAUD_W-1:0]      baud_q;
    logic [BAUD_W-1:0]      cnt_q;
    logic [BAUD_W-1:0]      half_m1;
    logic [BAUD_W-1:0]      full_m1;
    logic [3:0]             n_q;
    logic [3:0]             bitcnt_q;
    logic [9:0]             shreg_q;
    logic                   half_hit;
    logic                   bit_hit;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign half_m1 = (baud_q >> 1) - ONE;
    assign full_m1 = baud_q - ONE;
    assign half_hit = (cnt_q == half_m1);
    assign bit_hit  = (cnt_q == full_m1);

    // Next-state logic: start qualification at half a bit, then N full-bit samples
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (half_hit) state_d = rx_s ? IDLE : DATA;
            DATA:    if (bit_hit && (bitcnt_q == n_q - 4'd1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, synchroniser, counters, shift register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            sync_q        <= '1;
            baud_q        <= '0;
            cnt_q         <= '0;
            n_q           <= '0;
            bitcnt_q      <= '0;
            shreg_q       <= '0;
            bus.shiftData <= '0;
            bus.eight_q   <= 1'b0;
            bus.pen_q     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.ferr      <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.rx};
            bus.done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        // Configuration is frozen here so mid-frame changes are ignored
                        bus.eight_q <= bus.eight;
                        bus.pen_q   <= bus.pen;
                        baud_q      <= bus.baud_k;
                        n_q         <= 4'd8 + {3'b000, bus.eight} + {3'b000, bus.pen};
                        cnt_q       <= '0;
                        shreg_q     <= '0;
                        bus.busy    <= 1'b1;
                    end
                end
                START: begin
                    if (half_hit) begin
                        cnt_q    <= '0;
                        bitcnt_q <= '0;
                        if (rx_s) bus.busy <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                DATA: begin
                    if (bit_hit) begin
                        cnt_q    <= '0;
                        shreg_q  <= {rx_s, shreg_q[9:1]};
                        bitcnt_q <= bitcnt_q + 4'd1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                DONE: begin
                    // Bits entered at the top; shift down so the first data bit lands at bit 0
                    bus.shiftData <= shreg_q >> (4'd10 - n_q);
                    bus.ferr      <= ~shreg_q[9];
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
